vq_compress_ctrl: RTL and testbench
===================================

// Module: vq_compress_ctrl
// PURPOSE
//  Sequencer for the 8-entry Manhattan-distance codebook unit in the compress path.
//  Loads 8 RGB codewords from codebook ROM, then streams NUM_PIX pixels from image ROM.
//  Picks the nearest codeword (argmin of d0..d7) for each pixel and writes its 3-bit index to index RAM.
//  Accumulates total quantisation error. Sits between the ROMs/RAM and the distance unit.
// PARAMETERS
//  NUM_PIX  4096  pixels per frame
//  PIX_AW   12    pixel/index address width (2^PIX_AW >= NUM_PIX)
//  DW       10    distance width from distance unit (max value 765)
//  ERR_W    22    error accumulator width (765*4096 < 2^22)
// PORTS
//  clk         in   1        single clock, all logic on posedge
//  rst         in   1        synchronous, active-high reset
//  start       in   1        1-cycle pulse, begins a frame when idle
//  busy        out  1        high from accepted start until done
//  done        out  1        1-cycle pulse after last index write
//  cb_addr     out  3        codebook ROM address (sync ROM, data valid next cycle)
//  cb_data     in   24       codebook ROM data {R,G,B}
//  px_addr     out  PIX_AW   image ROM address (sync ROM, data valid next cycle)
//  px_data     in   24       image ROM data {R,G,B}
//  man_data    out  24       data bus to distance unit (cb_data in LOAD, px_data otherwise)
//  man_wen     out  1        codeword write enable to distance unit
//  man_addr_w  out  3        codeword slot
//  man_data_en out  1        pixel capture enable to distance unit
//  d_in        in   8*DW     distances {d7..d0}, combinational from unit registers
//  idx_wen     out  1        index RAM write enable
//  idx_addr    out  PIX_AW   index RAM address
//  idx_data    out  3        nearest codeword index
//  err_sum     out  ERR_W    sum of min distances for the current/last frame
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, man_wen, man_data_en, idx_wen = 0; all addresses, idx_data, err_sum = 0.
//  Reset mid-frame aborts immediately. No write strobe is issued on the cycle after rst.
//  FSM states: IDLE, LOAD, STREAM, DRAIN, FIN.
//  IDLE: start=1 -> LOAD. Clear err_sum, cb_addr=0, busy=1. Start while busy is ignored.
//  LOAD: issue cb_addr 0..7 on 8 consecutive cycles.
//   - man_wen=1 and man_addr_w=k on the cycle after cb_addr=k (9 cycles in LOAD).
//   - After slot 7 is written -> STREAM with px_addr=0.
//  STREAM: issue px_addr 0..NUM_PIX-1, one per cycle. 3-stage pipeline per pixel:
//   - T: px_addr=n.
//   - T+1: man_data=px_data, man_data_en=1 (unit registers the pixel at the end of T+1).
//   - T+2: d_in is valid. Combinational argmin; ties resolve to the LOWEST index.
//   - T+3: idx_wen=1, idx_addr=n, idx_data=argmin (registered). err_sum += min distance at the same edge.
//  After px_addr=NUM_PIX-1 is issued -> DRAIN. Hold px_addr at the last value; no wrap to 0.
//  DRAIN: runs until the pipeline empties (last idx_wen) -> FIN.
//  FIN: done=1 for one cycle, busy=0 -> IDLE. err_sum holds until the next start.
//  man_wen and man_data_en are never high in the same cycle.
//  Throughput: one index per cycle in steady state. Frame length = 1 + 9 + NUM_PIX + 3 + 1 cycles ±1.
//  Arithmetic: compare unsigned DW-bit values; zero-extend the min to ERR_W before accumulating; no saturation needed.
// TESTING
//  1. Codebook {0,0x101010,..,0x707070}; pixel 0x303030 everywhere.
//     -> all 4096 idx_data=3; err_sum=0; done once; idx_addr 0..4095 in order, no gaps.
//  2. All codewords identical -> every idx_data=0 (tie rule). Pixel 0x000000, cw=0x010101 -> err_sum=3*4096=12288.
//  3. Extreme values: cw0=0x000000, cw1=0xFFFFFF, pixel 0xFFFFFF -> idx 1.
//     Pixel 0x7F7F7F -> idx 0 (d0=381 < d1=384).
//     Check d=765 handled without overflow.
//  4. Assert start during STREAM -> ignored: no restart, idx_addr continues monotonic, single done.
//  5. Assert rst at pixel 2000 -> next cycle busy=0, idx_wen=0, err_sum=0, state IDLE.
//     A fresh start then runs a full correct frame.
//  6. Back-to-back frames (start on the cycle after done) with a new codebook
//     -> second frame uses the new codewords only; err_sum restarts from 0.

Source files
------------

// File: rtl/vq_compress_ctrl.sv
// rtl/vq_compress_ctrl.sv - frame sequencer for the 8-entry Manhattan-distance VQ codebook unit
// Loads 8 codewords, streams pixels through a 3-stage pipeline, writes argmin indices and sums the error.
module vq_compress_ctrl #(
  parameter int NUM_PIX = 4096,
  parameter int PIX_AW  = 12,
  parameter int DW      = 10,
  parameter int ERR_W   = 22
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [2:0]          cb_addr,
  input  logic [23:0]         cb_data,
  output logic [PIX_AW-1:0]   px_addr,
  input  logic [23:0]         px_data,
  output logic [23:0]         man_data,
  output logic                man_wen,
  output logic [2:0]          man_addr_w,
  output logic                man_data_en,
  input  logic [8*DW-1:0]     d_in,
  output logic                idx_wen,
  output logic [PIX_AW-1:0]   idx_addr,
  output logic [2:0]          idx_data,
  output logic [ERR_W-1:0]    err_sum
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN, S_FIN} state_t;

  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(NUM_PIX - 1);

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [2:0]          cb_addr_q, cb_addr_d;
  logic [3:0]          ld_cnt_q, ld_cnt_d;
  logic [PIX_AW-1:0]   px_addr_q, px_addr_d;
  logic                man_wen_q, man_wen_d;
  logic [2:0]          man_addr_w_q, man_addr_w_d;
  logic                man_data_en_q, man_data_en_d;
  logic [PIX_AW-1:0]   a1_q, a1_d;
  logic                v2_q, v2_d;
  logic [PIX_AW-1:0]   a2_q, a2_d;
  logic                idx_wen_q, idx_wen_d;
  logic [PIX_AW-1:0]   idx_addr_q, idx_addr_d;
  logic [2:0]          idx_data_q, idx_data_d;
  logic [ERR_W-1:0]    err_sum_q, err_sum_d;

  logic [2:0]          min_idx;
  logic [DW-1:0]       min_dist;
  logic [DW-1:0]       d_k;

  // Strict less-than keeps the earliest slot on ties.
  always_comb begin
    min_idx  = 3'd0;
    min_dist = d_in[DW-1:0];
    d_k      = '0;
    for (int k = 1; k < 8; k++) begin
      d_k = d_in[k*DW +: DW];
      if (d_k < min_dist) begin
        min_dist = d_k;
        min_idx  = 3'(k);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cb_addr_d     = cb_addr_q;
    ld_cnt_d      = ld_cnt_q;
    px_addr_d     = px_addr_q;
    man_wen_d     = 1'b0;
    man_addr_w_d  = man_addr_w_q;
    man_data_en_d = 1'b0;
    a1_d          = px_addr_q;
    v2_d          = man_data_en_q;
    a2_d          = a1_q;
    idx_wen_d     = 1'b0;
    idx_addr_d    = idx_addr_q;
    idx_data_d    = idx_data_q;
    err_sum_d     = err_sum_q;

    if (v2_q) begin
      idx_wen_d  = 1'b1;
      idx_addr_d = a2_q;
      idx_data_d = min_idx;
      err_sum_d  = err_sum_q + ERR_W'(min_dist);
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          err_sum_d = '0;
          cb_addr_d = 3'd0;
          ld_cnt_d  = 4'd0;
        end
      end
      S_LOAD: begin
        // Counts 0..7 issue ROM addresses; count 8 is the cycle slot 7 gets written.
        if (!ld_cnt_q[3]) begin
          man_wen_d    = 1'b1;
          man_addr_w_d = cb_addr_q;
          ld_cnt_d     = ld_cnt_q + 4'd1;
          if (cb_addr_q != 3'd7) begin
            cb_addr_d = cb_addr_q + 3'd1;
          end
        end else begin
          state_d   = S_STREAM;
          px_addr_d = '0;
        end
      end
      S_STREAM: begin
        man_data_en_d = 1'b1;
        if (px_addr_q == LAST_PIX) begin
          state_d = S_DRAIN;
        end else begin
          px_addr_d = px_addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (idx_wen_q && (idx_addr_q == LAST_PIX)) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cb_addr_q     <= '0;
      ld_cnt_q      <= '0;
      px_addr_q     <= '0;
      man_wen_q     <= 1'b0;
      man_addr_w_q  <= '0;
      man_data_en_q <= 1'b0;
      a1_q          <= '0;
      v2_q          <= 1'b0;
      a2_q          <= '0;
      idx_wen_q     <= 1'b0;
      idx_addr_q    <= '0;
      idx_data_q    <= '0;
      err_sum_q     <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cb_addr_q     <= cb_addr_d;
      ld_cnt_q      <= ld_cnt_d;
      px_addr_q     <= px_addr_d;
      man_wen_q     <= man_wen_d;
      man_addr_w_q  <= man_addr_w_d;
      man_data_en_q <= man_data_en_d;
      a1_q          <= a1_d;
      v2_q          <= v2_d;
      a2_q          <= a2_d;
      idx_wen_q     <= idx_wen_d;
      idx_addr_q    <= idx_addr_d;
      idx_data_q    <= idx_data_d;
      err_sum_q     <= err_sum_d;
    end
  end

  // ROM data for the address issued last cycle goes straight to the distance unit.
  assign man_data    = (state_q == S_LOAD) ? cb_data : px_data;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cb_addr     = cb_addr_q;
  assign px_addr     = px_addr_q;
  assign man_wen     = man_wen_q;
  assign man_addr_w  = man_addr_w_q;
  assign man_data_en = man_data_en_q;
  assign idx_wen     = idx_wen_q;
  assign idx_addr    = idx_addr_q;
  assign idx_data    = idx_data_q;
  assign err_sum     = err_sum_q;

endmodule

// File: tb/tb_vq_compress_ctrl.sv
// tb/tb_vq_compress_ctrl.sv - directed self-checking bench for vq_compress_ctrl
module tb_vq_compress_ctrl;
  localparam int NUM_PIX   = 4096;
  localparam int PIX_AW    = 12;
  localparam int DW        = 10;
  localparam int ERR_W     = 22;
  localparam int FRAME_CYC = 1 + 9 + NUM_PIX + 3 + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic              done;
  logic [2:0]        cb_addr;
  logic [23:0]       cb_data;
  logic [PIX_AW-1:0] px_addr;
  logic [23:0]       px_data;
  logic [23:0]       man_data;
  logic              man_wen;
  logic [2:0]        man_addr_w;
  logic              man_data_en;
  logic [8*DW-1:0]   d_in;
  logic              idx_wen;
  logic [PIX_AW-1:0] idx_addr;
  logic [2:0]        idx_data;
  logic [ERR_W-1:0]  err_sum;

  vq_compress_ctrl #(
    .NUM_PIX(NUM_PIX), .PIX_AW(PIX_AW), .DW(DW), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cb_addr(cb_addr), .cb_data(cb_data), .px_addr(px_addr), .px_data(px_data),
    .man_data(man_data), .man_wen(man_wen), .man_addr_w(man_addr_w),
    .man_data_en(man_data_en), .d_in(d_in), .idx_wen(idx_wen),
    .idx_addr(idx_addr), .idx_data(idx_data), .err_sum(err_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ROMs: even/odd pixel addresses may carry different colours
  logic [23:0] cb_rom [8];
  logic [23:0] pix_even, pix_odd;

  always @(posedge clk) begin
    cb_data <= cb_rom[cb_addr];
    px_data <= px_addr[0] ? pix_odd : pix_even;
  end

  // Distance unit
  logic [23:0] cw [8];
  logic [23:0] pix_reg;

  always @(posedge clk) begin
    if (man_wen) cw[man_addr_w] <= man_data;
    if (man_data_en) pix_reg <= man_data;
  end

  function automatic logic [9:0] absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? 10'(a - b) : 10'(b - a);
  endfunction

  function automatic logic [9:0] mdist(input logic [23:0] a, input logic [23:0] b);
    return absd(a[23:16], b[23:16]) + absd(a[15:8], b[15:8]) + absd(a[7:0], b[7:0]);
  endfunction

  always_comb begin
    d_in = '0;
    for (int k = 0; k < 8; k++) d_in[k*DW +: DW] = mdist(cw[k], pix_reg);
  end

  // Write-stream monitor
  int         exp_addr;
  int         exp_slot;
  logic [2:0] exp_even, exp_odd;

  always @(negedge clk) begin
    if (!rst) begin
      if (idx_wen) begin
        chk("idx_addr", 32'(idx_addr), exp_addr);
        chk("idx_data", 32'(idx_data), 32'(exp_addr[0] ? exp_odd : exp_even));
        exp_addr++;
      end
      if (man_wen) begin
        chk("man_slot", 32'(man_addr_w), exp_slot);
        chk("man_cw", 32'(man_data), 32'(cb_rom[exp_slot[2:0]]));
        exp_slot++;
      end
      if (man_wen || man_data_en) chk("wen_excl", 32'(man_wen & man_data_en), 0);
    end
  end

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [ERR_W-1:0] eerr, input bit stray);
    int  ncyc;
    bit  got;
    exp_addr = 0;
    exp_slot = 0;
    start_pulse();
    chk({tag, ".busy_start"}, 32'(busy), 1);
    ncyc = 2;
    got  = 1'b0;
    while (!got && ncyc < FRAME_CYC + 50) begin
      start = stray && (ncyc == 300 || ncyc == 2000 || ncyc == 2001);
      @(negedge clk);
      ncyc++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(got), 1);
    chk({tag, ".frame_len"}, ncyc, FRAME_CYC);
    chk({tag, ".idx_count"}, exp_addr, NUM_PIX);
    chk({tag, ".err_sum"}, 32'(err_sum), 32'(eerr));
    chk({tag, ".busy_fin"}, 32'(busy), 0);
  endtask

  task automatic set_cb_lin();
    for (int k = 0; k < 8; k++) cb_rom[k] = 24'(k) * 24'h101010;
  endtask

  task automatic set_cb_all(input logic [23:0] v);
    for (int k = 0; k < 8; k++) cb_rom[k] = v;
  endtask

  bit busy_seen;
  bit wen_seen;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    set_cb_all(24'h0);
    pix_even = 24'h0;
    pix_odd = 24'h0;
    exp_even = 3'd0;
    exp_odd = 3'd0;
    exp_addr = 0;
    exp_slot = 0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.idx_wen", 32'(idx_wen), 0);
    chk("rst.man_wen", 32'(man_wen), 0);
    chk("rst.man_data_en", 32'(man_data_en), 0);
    chk("rst.err_sum", 32'(err_sum), 0);
    chk("rst.cb_addr", 32'(cb_addr), 0);
    chk("rst.px_addr", 32'(px_addr), 0);
    chk("rst.idx_addr", 32'(idx_addr), 0);
    chk("rst.idx_data", 32'(idx_data), 0);
    rst = 1'b0;

    // Linear codebook, mid-grey pixel
    set_cb_lin();
    pix_even = 24'h303030; pix_odd = 24'h303030;
    exp_even = 3'd3; exp_odd = 3'd3;
    run_frame("t1", 22'd0, 1'b0);

    // Alternating pixels pin each index to its own address
    pix_odd = 24'h707070; exp_odd = 3'd7;
    run_frame("t1b", 22'd0, 1'b0);

    // Identical codewords: tie goes to slot 0
    set_cb_all(24'h010101);
    pix_even = 24'h0; pix_odd = 24'h0;
    exp_even = 3'd0; exp_odd = 3'd0;
    run_frame("t2", 22'd12288, 1'b0);

    // Extreme values
    set_cb_all(24'h0);
    cb_rom[1] = 24'hFFFFFF;
    pix_even = 24'hFFFFFF; pix_odd = 24'hFFFFFF;
    exp_even = 3'd1; exp_odd = 3'd1;
    run_frame("t3a", 22'd0, 1'b0);
    pix_even = 24'h7F7F7F; pix_odd = 24'h7F7F7F;
    exp_even = 3'd0; exp_odd = 3'd0;
    run_frame("t3b", 22'd1560576, 1'b0);
    cb_rom[1] = 24'h0;
    pix_even = 24'hFFFFFF; pix_odd = 24'hFFFFFF;
    run_frame("t3c", 22'd3133440, 1'b0);

    // Stray starts while streaming
    set_cb_lin();
    pix_even = 24'h383838; pix_odd = 24'h383838;
    exp_even = 3'd3; exp_odd = 3'd3;
    run_frame("t4", 22'd98304, 1'b1);
    busy_seen = 1'b0;
    wen_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (idx_wen || man_wen) wen_seen = 1'b1;
    end
    chk("t4.no_restart", 32'(busy_seen), 0);
    chk("t4.no_writes", 32'(wen_seen), 0);
    chk("t4.err_hold", 32'(err_sum), 98304);

    // Reset mid-frame
    set_cb_all(24'h010101);
    pix_even = 24'h0; pix_odd = 24'h0;
    exp_even = 3'd0; exp_odd = 3'd0;
    exp_addr = 0;
    exp_slot = 0;
    start_pulse();
    for (int i = 0; i < NUM_PIX + 50 && px_addr != 12'd2000; i++) @(negedge clk);
    chk("t5.reach", 32'(px_addr == 12'd2000), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5.busy", 32'(busy), 0);
    chk("t5.idx_wen", 32'(idx_wen), 0);
    chk("t5.err_sum", 32'(err_sum), 0);
    chk("t5.done", 32'(done), 0);
    chk("t5.px_addr", 32'(px_addr), 0);
    chk("t5.man_data_en", 32'(man_data_en), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5.post_idx_wen", 32'(idx_wen), 0);
    chk("t5.post_man_wen", 32'(man_wen), 0);
    chk("t5.post_busy", 32'(busy), 0);
    run_frame("t5.fresh", 22'd12288, 1'b0);

    // Back-to-back frames with a new codebook
    set_cb_lin();
    pix_even = 24'h383838; pix_odd = 24'h383838;
    exp_even = 3'd3; exp_odd = 3'd3;
    run_frame("t6a", 22'd98304, 1'b0);
    for (int k = 0; k < 8; k++) cb_rom[k] = 24'(7 - k) * 24'h101010 + 24'h090909;
    exp_even = 3'd4; exp_odd = 3'd4;
    run_frame("t6b", 22'd12288, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
